// File: rtl/sdram_multi_arbit_if.sv
// ---------------------------------------------------------------------------
// sdram_multi_arbit_if
//
// Bundles every signal between the SDRAM arbiter and its neighbours: the init
// sequencer, the auto-refresh engine, NUM_CH access channels and the SDRAM
// command pins.
//
// Parameters:
//   NUM_CH  number of access channels (1..8)
//   ADDR_W  SDRAM address width
//
// Modports:
//   slave   the arbiter: takes the source fields, drives enables and the bus
//   master  the surrounding engines/pins model: the opposite directions
//
// Signal summary:
//   init_cmd/bank/addr/end     init source fields and completion flag
//   atref_req/end/cmd/bank/addr refresh request, completion and fields
//   ch_req/ch_end              per-channel request and completion
//   ch_cmd/ch_bank/ch_addr     packed channel fields, channel i at slice i
//   atref_en, ch_en            refresh enable, one-hot channel enable
//   grant_id                   current/last granted channel
//   sdram_cmd/bank/addr        muxed command bus {cs_n,ras_n,cas_n,we_n}
//   cur_state                  INIT=0, ARBIT=1, AUTO_REFRESH=2, ACCESS=3
//   arb_timeout                one-cycle watchdog pulse
// ---------------------------------------------------------------------------
interface sdram_multi_arbit_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 13
);
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [3:0]               init_cmd;
  logic [1:0]               init_bank;
  logic [ADDR_W-1:0]        init_addr;
  logic                     init_end;

  logic                     atref_req;
  logic                     atref_end;
  logic [3:0]               atref_cmd;
  logic [1:0]               atref_bank;
  logic [ADDR_W-1:0]        atref_addr;

  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_end;
  logic [4*NUM_CH-1:0]      ch_cmd;
  logic [2*NUM_CH-1:0]      ch_bank;
  logic [ADDR_W*NUM_CH-1:0] ch_addr;

  logic                     atref_en;
  logic [NUM_CH-1:0]        ch_en;
  logic [ID_W-1:0]          grant_id;
  logic [3:0]               sdram_cmd;
  logic [1:0]               sdram_bank;
  logic [ADDR_W-1:0]        sdram_addr;
  logic [1:0]               cur_state;
  logic                     arb_timeout;

  modport slave (
    input  init_cmd, init_bank, init_addr, init_end,
    input  atref_req, atref_end, atref_cmd, atref_bank, atref_addr,
    input  ch_req, ch_end, ch_cmd, ch_bank, ch_addr,
    output atref_en, ch_en, grant_id,
    output sdram_cmd, sdram_bank, sdram_addr,
    output cur_state, arb_timeout
  );

  modport master (
    output init_cmd, init_bank, init_addr, init_end,
    output atref_req, atref_end, atref_cmd, atref_bank, atref_addr,
    output ch_req, ch_end, ch_cmd, ch_bank, ch_addr,
    input  atref_en, ch_en, grant_id,
    input  sdram_cmd, sdram_bank, sdram_addr,
    input  cur_state, arb_timeout
  );
endinterface

// File: rtl/sdram_multi_arbit.sv
// ---------------------------------------------------------------------------
// sdram_multi_arbit
//
// SDRAM command arbiter: runs INIT until the init sequencer finishes, then
// loops through ARBIT and either AUTO_REFRESH or ACCESS. Refresh wins at
// every ARBIT cycle; access channels are served round-robin starting at the
// channel after the last one that completed. The winning source's command,
// bank and address are muxed onto the SDRAM command bus.
//
// Parameters:
//   NUM_CH       number of access channels (1..8)
//   ADDR_W       SDRAM address width
//   TIMEOUT_CYC  watchdog limit in cycles (only with SDRAM_ARB_TIMEOUT_EN)
//
// Ports:
//   sys_clk  system clock, rising edge
//   sys_rst  synchronous active-high reset
//   bus      sdram_multi_arbit_if.slave (sources, enables, command bus)
//
// Build option:
//   SDRAM_ARB_TIMEOUT_EN  when defined, a 16-bit watchdog forces ARBIT after
//                         TIMEOUT_CYC cycles in ACCESS/AUTO_REFRESH without
//                         the matching end and pulses arb_timeout. When not
//                         defined, arb_timeout is tied low and operations
//                         wait indefinitely for their end.
// ---------------------------------------------------------------------------
module sdram_multi_arbit #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 13,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic                sys_clk,
  input logic                sys_rst,
  sdram_multi_arbit_if.slave bus
);

  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    INIT         = 2'd0,
    ARBIT        = 2'd1,
    AUTO_REFRESH = 2'd2,
    ACCESS       = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   next_grant;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   next_rr;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   grant_inc;
  logic [ID_W:0]     pick_sum;
  logic [ID_W:0]     inc_sum;
  logic              pick_found;
  logic              grant_end;
  logic [NUM_CH-1:0] grant_onehot;
  logic              atref_en;
  logic [NUM_CH-1:0] ch_en;
  logic [3:0]        cmd_mux;
  logic [1:0]        bank_mux;
  logic [ADDR_W-1:0] addr_mux;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] timer;
  logic        timeout_hit;
  logic        timeout_pulse;
`else
  // Without the watchdog the limit has no effect; the empty guard keeps the
  // parameter referenced so every build shares one parameter list.
  if (TIMEOUT_CYC < 0) begin : g_timeout_unused
  end
`endif

  // Round-robin search: walk rr_ptr, rr_ptr+1, ... (mod NUM_CH) and take the
  // first requesting channel. Indices wrap by a single conditional subtract
  // so NUM_CH need not be a power of two.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = rr_ptr;
    pick_sum   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pick_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (pick_sum >= (ID_W+1)'(NUM_CH)) begin
        pick_sum = pick_sum - (ID_W+1)'(NUM_CH);
      end
      if (!pick_found && (|(bus.ch_req & (NUM_CH'(1) << pick_sum)))) begin
        pick_found = 1'b1;
        pick_id    = pick_sum[ID_W-1:0];
      end
    end
  end

  // Channel after the granted one, wrapped; becomes the next round-robin
  // start once the granted channel finishes. Only the granted channel's end
  // is honoured, so stray ends from other channels are masked here.
  always_comb begin
    inc_sum      = {1'b0, grant_id} + (ID_W+1)'(1);
    grant_inc    = (inc_sum == (ID_W+1)'(NUM_CH)) ? '0 : inc_sum[ID_W-1:0];
    grant_onehot = NUM_CH'(1) << grant_id;
    grant_end    = |(bus.ch_end & grant_onehot);
  end

  // Next-state decision. Refresh is checked before the channels in ARBIT, and
  // nothing but the matching end (or the watchdog) leaves an operation, so a
  // pending refresh and an in-flight access never preempt one another.
  always_comb begin
    next_state = state;
    next_grant = grant_id;
    next_rr    = rr_ptr;
`ifdef SDRAM_ARB_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      INIT: begin
        if (bus.init_end) begin
          next_state = ARBIT;
        end
      end
      ARBIT: begin
        if (bus.atref_req) begin
          next_state = AUTO_REFRESH;
        end else if (pick_found) begin
          next_state = ACCESS;
          next_grant = pick_id;
        end
      end
      AUTO_REFRESH: begin
        if (bus.atref_end) begin
          next_state = ARBIT;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (timer == TIMEOUT_LAST) begin
          next_state  = ARBIT;
          timeout_hit = 1'b1;
        end
`endif
      end
      ACCESS: begin
        if (grant_end) begin
          next_state = ARBIT;
          next_rr    = grant_inc;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (timer == TIMEOUT_LAST) begin
          next_state  = ARBIT;
          next_rr     = grant_inc;
          timeout_hit = 1'b1;
        end
`endif
      end
      default: begin
        next_state = INIT;
      end
    endcase
  end

  // State, grant and pointer registers. The enables are registered from the
  // next state so they line up exactly with cur_state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= INIT;
      grant_id <= '0;
      rr_ptr   <= '0;
      atref_en <= 1'b0;
      ch_en    <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      timer         <= '0;
      timeout_pulse <= 1'b0;
`endif
    end else begin
      state    <= next_state;
      grant_id <= next_grant;
      rr_ptr   <= next_rr;
      atref_en <= (next_state == AUTO_REFRESH);
      ch_en    <= (next_state == ACCESS) ? (NUM_CH'(1) << next_grant) : '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      // The watchdog restarts on each entry from ARBIT and counts every
      // cycle spent inside the operation.
      if ((state == ARBIT) &&
          ((next_state == ACCESS) || (next_state == AUTO_REFRESH))) begin
        timer <= '0;
      end else if ((state == ACCESS) || (state == AUTO_REFRESH)) begin
        timer <= timer + 16'd1;
      end
      timeout_pulse <= timeout_hit;
`endif
    end
  end

  // Command bus mux. ARBIT drives a NOP with bank/address cleared; ACCESS
  // picks the granted channel's slices.
  always_comb begin
    cmd_mux  = 4'b0111;
    bank_mux = 2'b00;
    addr_mux = '0;
    case (state)
      INIT: begin
        cmd_mux  = bus.init_cmd;
        bank_mux = bus.init_bank;
        addr_mux = bus.init_addr;
      end
      AUTO_REFRESH: begin
        cmd_mux  = bus.atref_cmd;
        bank_mux = bus.atref_bank;
        addr_mux = bus.atref_addr;
      end
      ACCESS: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (grant_id == ID_W'(i)) begin
            cmd_mux  = bus.ch_cmd[i*4 +: 4];
            bank_mux = bus.ch_bank[i*2 +: 2];
            addr_mux = bus.ch_addr[i*ADDR_W +: ADDR_W];
          end
        end
      end
      default: begin
        cmd_mux  = 4'b0111;
        bank_mux = 2'b00;
        addr_mux = '0;
      end
    endcase
  end

  assign bus.cur_state  = state;
  assign bus.grant_id   = grant_id;
  assign bus.atref_en   = atref_en;
  assign bus.ch_en      = ch_en;
  assign bus.sdram_cmd  = cmd_mux;
  assign bus.sdram_bank = bank_mux;
  assign bus.sdram_addr = addr_mux;

`ifdef SDRAM_ARB_TIMEOUT_EN
  assign bus.arb_timeout = timeout_pulse;
`else
  assign bus.arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_multi_arbit.sv
// ---------------------------------------------------------------------------
// tb_sdram_multi_arbit
//
// Self-checking bench for sdram_multi_arbit (NUM_CH=4, ADDR_W=13, default
// build without SDRAM_ARB_TIMEOUT_EN). A behavioural model tracks the
// arbiter phase, the granted channel and the round-robin start; every cycle
// the DUT outputs are compared against it. Directed sequences cover init
// timing, round-robin order, refresh priority, stray ends and mid-access
// reset, followed by randomized inputs.
// ---------------------------------------------------------------------------
module tb_sdram_multi_arbit;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 13;

  logic sysClk = 1'b0;
  logic sysRst = 1'b1;

  always #5 sysClk = ~sysClk;

  sdram_multi_arbit_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

  sdram_multi_arbit #(
    .NUM_CH(NUM_CH),
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYC(1024)
  ) dut (
    .sys_clk(sysClk),
    .sys_rst(sysRst),
    .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Model: phase 0=INIT 1=ARBIT 2=AUTO_REFRESH 3=ACCESS, plus the cycle
  // count spent in the current phase (1 on the first cycle).
  int mState = 0;
  int mGrant = 0;
  int mRr    = 0;
  int mCnt   = 0;

  // Compares one observed value against its expectation and tallies it.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advances the model over one clock edge using the inputs held at it.
  task automatic modelStep();
    int prev;
    prev = mState;
    if (sysRst) begin
      mState = 0;
      mGrant = 0;
      mRr    = 0;
    end else begin
      case (mState)
        0: if (bus.init_end) mState = 1;
        1: begin
          if (bus.atref_req) begin
            mState = 2;
          end else if (bus.ch_req != 0) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (((bus.ch_req >> ((mRr + k) % NUM_CH)) & 1) != 0) begin
                mGrant = (mRr + k) % NUM_CH;
                break;
              end
            end
            mState = 3;
          end
        end
        2: if (bus.atref_end) mState = 1;
        default: begin
          if (((bus.ch_end >> mGrant) & 1) != 0) begin
            mState = 1;
            mRr    = (mGrant + 1) % NUM_CH;
          end
        end
      endcase
    end
    mCnt = (mState != prev) ? 1 : mCnt + 1;
  endtask

  // Compares all DUT outputs with what the model says for this cycle.
  task automatic checkAll();
    logic [3:0]        expCmd;
    logic [1:0]        expBank;
    logic [ADDR_W-1:0] expAddr;
    logic [3:0]        expChEn;
    expChEn = (mState == 3) ? 4'(1 << mGrant) : 4'b0;
    case (mState)
      0: begin
        expCmd = bus.init_cmd; expBank = bus.init_bank; expAddr = bus.init_addr;
      end
      2: begin
        expCmd = bus.atref_cmd; expBank = bus.atref_bank; expAddr = bus.atref_addr;
      end
      3: begin
        expCmd  = 4'(bus.ch_cmd >> (mGrant * 4));
        expBank = 2'(bus.ch_bank >> (mGrant * 2));
        expAddr = ADDR_W'(bus.ch_addr >> (mGrant * ADDR_W));
      end
      default: begin
        expCmd = 4'b0111; expBank = 2'b00; expAddr = '0;
      end
    endcase
    checkOutput("cur_state", 32'(bus.cur_state), 32'(mState));
    checkOutput("grant_id", 32'(bus.grant_id), 32'(mGrant));
    checkOutput("ch_en", 32'(bus.ch_en), 32'(expChEn));
    checkOutput("atref_en", 32'(bus.atref_en), 32'(mState == 2));
    checkOutput("arb_timeout", 32'(bus.arb_timeout), 32'(0));
    checkOutput("sdram_cmd", 32'(bus.sdram_cmd), 32'(expCmd));
    checkOutput("sdram_bank", 32'(bus.sdram_bank), 32'(expBank));
    checkOutput("sdram_addr", 32'(bus.sdram_addr), 32'(expAddr));
  endtask

  // Drives one cycle of control inputs with fresh random source fields, then
  // clocks the DUT and model and checks at the falling edge.
  task automatic applyStimulus(input logic initEnd, input logic atrefReq,
                               input logic atrefEnd, input logic [3:0] chReq,
                               input logic [3:0] chEnd);
    bus.init_end   = initEnd;
    bus.atref_req  = atrefReq;
    bus.atref_end  = atrefEnd;
    bus.ch_req     = chReq;
    bus.ch_end     = chEnd;
    bus.init_cmd   = 4'($urandom);
    bus.init_bank  = 2'($urandom);
    bus.init_addr  = ADDR_W'($urandom);
    bus.atref_cmd  = 4'($urandom);
    bus.atref_bank = 2'($urandom);
    bus.atref_addr = ADDR_W'($urandom);
    bus.ch_cmd     = 16'($urandom);
    bus.ch_bank    = 8'($urandom);
    bus.ch_addr    = 52'({$urandom, $urandom});
    @(posedge sysClk);
    #1;
    modelStep();
    @(negedge sysClk);
    checkAll();
  endtask

  int          expOrder[5] = '{0, 1, 2, 3, 0};
  int          grants[$];
  int          arbitCnt;
  logic [1:0]  prevDut;
  logic [3:0]  endMask;

  initial begin
    $display("[TB] start");

    // Reset
    sysRst = 1'b1;
    applyStimulus(0, 0, 0, 4'h0, 4'h0);
    applyStimulus(0, 0, 0, 4'hF, 4'hF);
    checkOutput("reset_state", 32'(bus.cur_state), 32'd0);
    checkOutput("reset_ch_en", 32'(bus.ch_en), 32'd0);
    sysRst = 1'b0;

    // Init: INIT holds until init_end pulses on cycle 10
    for (int c = 1; c < 10; c++) applyStimulus(0, 0, 0, 4'h0, 4'h0);
    checkOutput("init_hold", 32'(bus.cur_state), 32'd0);
    applyStimulus(1, 0, 0, 4'h0, 4'h0);
    checkOutput("init_to_arbit", 32'(bus.cur_state), 32'd1);
    checkOutput("arbit_nop", 32'(bus.sdram_cmd), 32'h7);

    // Round robin with all channels requesting, each ending 5 cycles in
    prevDut  = bus.cur_state;
    arbitCnt = 0;
    for (int c = 0; c < 80 && grants.size() < 5; c++) begin
      endMask = (mState == 3 && mCnt == 5) ? 4'(1 << mGrant) : 4'h0;
      applyStimulus(0, 0, 0, 4'hF, endMask);
      if (bus.cur_state == 2'd3 && prevDut != 2'd3) begin
        if (grants.size() > 0) checkOutput("rr_gap", 32'(arbitCnt), 32'd1);
        grants.push_back(int'(bus.grant_id));
        arbitCnt = 0;
      end else if (bus.cur_state == 2'd1) begin
        arbitCnt++;
      end
      prevDut = bus.cur_state;
    end
    checkOutput("rr_count", 32'(grants.size()), 32'd5);
    for (int g = 0; g < grants.size() && g < 5; g++)
      checkOutput("rr_order", 32'(grants[g]), 32'(expOrder[g]));
    for (int c = 0; c < 10 && mState == 3; c++) begin
      endMask = (mCnt >= 5) ? 4'(1 << mGrant) : 4'h0;
      applyStimulus(0, 0, 0, 4'h0, endMask);
    end

    // Refresh and ch2 together: refresh first, then ch2
    applyStimulus(0, 1, 0, 4'b0100, 4'h0);
    checkOutput("atref_first", 32'(bus.cur_state), 32'd2);
    checkOutput("atref_en_on", 32'(bus.atref_en), 32'd1);
    applyStimulus(0, 0, 0, 4'b0100, 4'h0);
    applyStimulus(0, 0, 1, 4'b0100, 4'h0);
    checkOutput("atref_done", 32'(bus.cur_state), 32'd1);
    applyStimulus(0, 0, 0, 4'b0100, 4'h0);
    checkOutput("ch2_after_ref", 32'(bus.grant_id), 32'd2);
    checkOutput("ch2_en", 32'(bus.ch_en), 32'b0100);
    applyStimulus(0, 0, 0, 4'h0, 4'b0100);

    // Refresh request during ch1 access waits for the access to finish
    applyStimulus(0, 0, 0, 4'b0010, 4'h0);
    checkOutput("ch1_grant", 32'(bus.grant_id), 32'd1);
    for (int c = 0; c < 3; c++) applyStimulus(0, 1, 0, 4'b0010, 4'h0);
    checkOutput("ch1_undisturbed", 32'(bus.cur_state), 32'd3);
    applyStimulus(0, 1, 0, 4'h0, 4'b0010);
    checkOutput("ch1_release", 32'(bus.cur_state), 32'd1);
    applyStimulus(0, 1, 0, 4'h0, 4'h0);
    checkOutput("ref_after_ch1", 32'(bus.cur_state), 32'd2);
    applyStimulus(0, 0, 1, 4'h0, 4'h0);

    // Stray ch_end[3] during ch0 access, then reset mid-access
    applyStimulus(0, 0, 0, 4'b0001, 4'h0);
    checkOutput("ch0_grant", 32'(bus.grant_id), 32'd0);
    applyStimulus(0, 0, 0, 4'b0001, 4'b1000);
    checkOutput("stray_ch_end", 32'(bus.cur_state), 32'd3);
    sysRst = 1'b1;
    applyStimulus(0, 0, 0, 4'b0001, 4'h0);
    sysRst = 1'b0;
    checkOutput("rst_mid_access", 32'(bus.cur_state), 32'd0);
    checkOutput("rst_ch_en", 32'(bus.ch_en), 32'd0);

    // Stray atref_end while in ARBIT
    applyStimulus(1, 0, 0, 4'h0, 4'h0);
    applyStimulus(0, 0, 1, 4'h0, 4'h0);
    checkOutput("stray_atref_end", 32'(bus.cur_state), 32'd1);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      sysRst = ($urandom_range(0, 149) == 0);
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) == 0), 4'($urandom),
                    4'($urandom) & 4'($urandom));
    end
    sysRst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
